prescaler_8bit_adj: RTL and testbench
=====================================

Name: prescaler_8bit_adj

Overview:
- Adjustable 8-bit prescaler (down-counter) clocked at 50 MHz.
- Advances only on a one-cycle clock-enable strobe `en`, typically the 1 kHz tick from a 50 MHz→1 kHz strobe generator.
- Divides the strobe rate by (preval+1) and emits a one-cycle `cnt_zero` pulse each period.
- Used in the DSM DAC top level as a programmable slow time base.

Parameters:
- WIDTH, 8, counter and preload width in bits; all behaviour below is for 8.

Ports:
- clk50m  input  1  system clock, 50 MHz, rising-edge active
- rst  input  1  reset; synchronous, active-high
- en  input  1  count-enable strobe, one clk50m cycle wide, arbitrary spacing
- preval  input  WIDTH  reload value; division ratio = preval+1
- cnt  output  WIDTH  current counter value, registered
- cnt_zero  output  1  terminal-count pulse, registered, one clk50m cycle

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- All state changes occur on rising clk50m.
- Reset (rst=1 at a rising edge):
  - cnt <= 0, cnt_zero <= 0.
  - Reset has priority over en.
  - Mid-operation reset aborts the current period with no pulse.
- en=0 (and rst=0): cnt holds; cnt_zero <= 0.
- en=1 (and rst=0):
  - If cnt==0: cnt <= preval and cnt_zero <= 1.
  - Else: cnt <= cnt-1 and cnt_zero <= 0.
- cnt_zero is high for exactly one clock, in the cycle after the en edge on which cnt was 0. Latency from the qualifying en to the pulse is 1 clock.
- First en after reset release: cnt is 0, so it produces a cnt_zero pulse and loads preval.
- Period: with steady preval = P, cnt_zero fires once every P+1 en strobes. Steady-state cnt sequence is P, P-1, …, 0, P, …
- preval=0: cnt stays 0 and cnt_zero fires on every en, i.e. pass-through of the strobe delayed 1 clock.
- preval=255: 256 strobes per pulse.
- preval is sampled only at reload (cnt==0 with en). Changes mid-period take effect at the next reload; no glitch and no early termination.
- No wrap-around below 0: the decrement never executes when cnt==0.
- en held high for multiple clocks is allowed; each clock with en=1 counts as one step.
- No combinational path from inputs to outputs.

Decomposition:
- Package prescaler_pkg:
  - CNT_W = 8.
  - CLK_HZ = 50_000_000.
  - TICK_HZ = 1_000.
  - DIV_1K = CLK_HZ/TICK_HZ = 50_000.
  - typedef cnt_t = logic [CNT_W-1:0].
- One natural sub-module: strobe_gen_50m_1k.
  - 16-bit counter, 0..DIV_1K-1, same clk50m/rst.
  - Emits a one-cycle en50m_1k when the counter wraps.
  - Instantiated beside prescaler_8bit_adj in the top level to drive `en`.
  - Internal counter resets to 0; its first pulse comes 50_000 clocks after reset release.
- The prescaler core itself is one always_ff block plus output assigns.

Test Plan:
- Reset: hold rst=1 for 1 µs with en toggling and preval=8'hFF → cnt=0, cnt_zero=0 throughout.
- preval=8'hFF, release rst, apply 600 en strobes:
  - Pulse after en #1, then after en #257 and en #513.
  - cnt reads 255 right after en #1 and 1 after en #255.
  - 250 strobes give exactly one pulse.
- preval=8'h7F: pulses spaced exactly 128 en strobes; cnt cycles 127→0.
- preval=8'h00: cnt_zero pulses one clock after every en; cnt stays 0.
- Change preval from 8'hFF to 8'h03 when cnt=100 → countdown continues 99…0, pulse, reload 3, then pulses every 4 strobes. Assert rst mid-count → cnt=0, no pulse, next en gives a pulse.
- Integration with strobe_gen_50m_1k and preval=8'h04 → en period 50_000 clocks (1 ms); cnt_zero every 5 ms, one 20 ns cycle wide.

Source files
------------

// File: rtl/prescaler_pkg.sv
// Shared constants and types for the adjustable prescaler and its 1 kHz strobe source.
package prescaler_pkg;

    localparam int CNT_W   = 8;
    localparam int CLK_HZ  = 50_000_000;
    localparam int TICK_HZ = 1_000;
    localparam int DIV_1K  = CLK_HZ / TICK_HZ;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage : prescaler_pkg

// File: rtl/prescaler_8bit_adj_strobe_gen.sv
// 50 MHz -> 1 kHz strobe generator: one-cycle pulse each time a 0..DIV_1K-1 counter wraps.
module strobe_gen_50m_1k
    import prescaler_pkg::*;
(
    input  logic clk50m,
    input  logic rst,
    output logic en50m_1k
);

    localparam logic [15:0] LAST_C = 16'(DIV_1K - 1);

    logic [15:0] div_q, div_d;
    logic        pulse_q, pulse_d;

    // Next-state: count up, wrap at the last value and flag the wrap.
    always_comb begin
        div_d   = div_q + 16'd1;
        pulse_d = 1'b0;
        if (div_q == LAST_C) begin
            div_d   = 16'd0;
            pulse_d = 1'b1;
        end
    end

    // State registers; first pulse lands DIV_1K clocks after reset release.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            div_q   <= 16'd0;
            pulse_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            pulse_q <= pulse_d;
        end
    end

    assign en50m_1k = pulse_q;

endmodule : strobe_gen_50m_1k

// File: rtl/prescaler_8bit_adj.sv
// Adjustable down-counting prescaler: divides the en strobe rate by (preval+1).
module prescaler_8bit_adj
    import prescaler_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk50m,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] preval,
    output logic [WIDTH-1:0] cnt,
    output logic             cnt_zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    // Next-state: reload preval (and pulse) at zero, otherwise step down; hold when idle.
    // preval is only looked at on reload, so mid-period changes wait for the next period.
    always_comb begin
        cnt_d  = cnt_q;
        zero_d = 1'b0;
        if (en) begin
            if (cnt_q == '0) begin
                cnt_d  = preval;
                zero_d = 1'b1;
            end else begin
                cnt_d  = cnt_q - WIDTH'(1);
            end
        end
    end

    // Counter and pulse registers; reset wins over en and drops any pending period.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_zero = zero_q;

endmodule : prescaler_8bit_adj

// File: tb/tb_prescaler_8bit_adj.sv
// Bench for prescaler_8bit_adj: scoreboard queue of per-cycle expectations plus directed spot checks.
module tb_prescaler_8bit_adj;
    import prescaler_pkg::*;

    logic       clk50m = 1'b0;
    logic       rst    = 1'b1;
    logic       tb_en  = 1'b0;
    logic       use_gen = 1'b0;
    logic [7:0] preval = 8'h00;
    logic [7:0] cnt;
    logic       cnt_zero;
    logic       gen_en;
    logic       dut_en;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] c;
        logic       z;
    } exp_t;

    exp_t sb[$];
    cnt_t m_cnt  = '0;
    logic m_zero = 1'b0;
    int   pulses[$];

    assign dut_en = use_gen ? gen_en : tb_en;

    always #10 clk50m = ~clk50m;

    prescaler_8bit_adj #(.WIDTH(8)) dut (
        .clk50m   (clk50m),
        .rst      (rst),
        .en       (dut_en),
        .preval   (preval),
        .cnt      (cnt),
        .cnt_zero (cnt_zero)
    );

    strobe_gen_50m_1k u_gen (
        .clk50m   (clk50m),
        .rst      (rst),
        .en50m_1k (gen_en)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Drive one clock of stimulus and push the expected outputs after that edge.
    task automatic step(input logic e, input logic r, input logic [7:0] pv);
        @(negedge clk50m);
        tb_en  = e;
        rst    = r;
        preval = pv;
        if (r) begin
            m_cnt  = '0;
            m_zero = 1'b0;
        end else if (e) begin
            if (m_cnt == '0) begin
                m_cnt  = pv;
                m_zero = 1'b1;
            end else begin
                m_cnt  = m_cnt - 8'd1;
                m_zero = 1'b0;
            end
        end else begin
            m_zero = 1'b0;
        end
        sb.push_back('{m_cnt, m_zero});
    endtask

    task automatic sample();
        @(posedge clk50m);
        #1;
    endtask

    // Monitor: after every edge, compare outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk50m);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_cnt", int'(cnt), int'(e.c));
                check("sb_cnt_zero", int'(cnt_zero), int'(e.z));
            end
        end
    end

    initial begin
        int hit;
        int first_gen;

        // Reset held 1 us with en toggling and preval=FF.
        for (int i = 0; i < 50; i++) step(logic'(i % 2), 1'b1, 8'hFF);

        // preval=FF, 600 back-to-back strobes.
        pulses.delete();
        for (int k = 1; k <= 600; k++) begin
            step(1'b1, 1'b0, 8'hFF);
            sample();
            if (cnt_zero) pulses.push_back(k);
            if (k == 1)   check("ff_cnt_after_1", int'(cnt), 255);
            if (k == 255) check("ff_cnt_after_255", int'(cnt), 1);
            if (k == 250) check("ff_pulses_in_250", pulses.size(), 1);
        end
        check("ff_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("ff_pulse0", pulses[0], 1);
            check("ff_pulse1", pulses[1], 257);
            check("ff_pulse2", pulses[2], 513);
        end

        // preval=7F, strobes with one idle cycle between them.
        step(1'b0, 1'b1, 8'h7F);
        pulses.delete();
        for (int k = 1; k <= 300; k++) begin
            step(1'b1, 1'b0, 8'h7F);
            sample();
            if (cnt_zero) pulses.push_back(k);
            if (k == 1)   check("7f_cnt_after_1", int'(cnt), 127);
            if (k == 128) check("7f_cnt_after_128", int'(cnt), 0);
            step(1'b0, 1'b0, 8'h7F);
        end
        check("7f_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("7f_pulse0", pulses[0], 1);
            check("7f_pulse1", pulses[1], 129);
            check("7f_pulse2", pulses[2], 257);
        end

        // preval=00: every strobe passes straight through one clock later.
        step(1'b0, 1'b1, 8'h00);
        pulses.delete();
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 8'h00);
            sample();
            if (cnt_zero) pulses.push_back(k);
            step(1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b0, 8'h00);
        end
        check("00_pulse_count", pulses.size(), 10);

        // preval FF -> 03 once cnt reaches 100; then a mid-count reset.
        step(1'b0, 1'b1, 8'hFF);
        pulses.delete();
        for (int k = 1; k <= 270; k++) begin
            step(1'b1, 1'b0, (k <= 156) ? 8'hFF : 8'h03);
            sample();
            if (cnt_zero) pulses.push_back(k);
            if (k == 156) check("chg_cnt_at_100", int'(cnt), 100);
            if (k == 256) check("chg_cnt_at_0", int'(cnt), 0);
            if (k == 257) check("chg_reload_3", int'(cnt), 3);
        end
        check("chg_pulse_count", pulses.size(), 5);
        if (pulses.size() == 5) begin
            check("chg_pulse1", pulses[1], 257);
            check("chg_pulse2", pulses[2], 261);
            check("chg_pulse4", pulses[4], 269);
        end
        check("chg_cnt_before_rst", int'(cnt), 2);
        step(1'b0, 1'b1, 8'h03);
        sample();
        check("midrst_cnt", int'(cnt), 0);
        check("midrst_zero", int'(cnt_zero), 0);
        step(1'b1, 1'b0, 8'h03);
        sample();
        check("midrst_next_pulse", int'(cnt_zero), 1);
        check("midrst_next_cnt", int'(cnt), 3);
        step(1'b0, 1'b0, 8'h03);
        sample();
        check("midrst_pulse_one_cycle", int'(cnt_zero), 0);

        repeat (3) @(posedge clk50m);
        #1;
        check("sb_drained", sb.size(), 0);

        // Integration with the 1 kHz strobe generator, preval=4.
        @(negedge clk50m);
        use_gen = 1'b1;
        tb_en   = 1'b0;
        preval  = 8'h04;
        rst     = 1'b1;
        repeat (3) @(negedge clk50m);
        rst = 1'b0;
        hit = 0;
        first_gen = 0;
        for (int n = 1; n <= 60000; n++) begin
            @(posedge clk50m);
            #1;
            if (gen_en && first_gen == 0) first_gen = n;
            if (cnt_zero) begin
                hit = n;
                break;
            end
        end
        check("int_first_strobe_clk", first_gen, 50000);
        check("int_first_pulse_clk", hit, 50001);
        check("int_cnt_loaded", int'(cnt), 4);
        sample();
        check("int_pulse_width", int'(cnt_zero), 0);
        check("int_strobe_width", int'(gen_en), 0);
        check("int_cnt_hold", int'(cnt), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_prescaler_8bit_adj
